sccb_responder: RTL

SCCB 2-wire responder (camera-side target) that decodes the transactions generated by the SCCB master on the same pins and serves them from a byte-wide register port. It sits on the FPGA fabric behind the SIO_C / SIO_D bidirectional buffer. It is used as a loopback target for master bring-up and as a camera register model in system test. All logic runs on XCLK; SIO_C and SIO_D are treated as asynchronous inputs and oversampled.

---
 rtl/sccb_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sccb_responder.sv
// SCCB camera-side responder: oversamples SIO_C/SIO_D on xclk, decodes ID/sub/data
// phases and serves a byte-wide register port. One write byte per transaction, one read byte.
//
// state  | meaning
// IDLE   | bus free, waiting for start
// ID     | shifting in device ID + R/W bit
// SUB    | shifting in sub-address
// WDATA  | shifting in write data
// RDATA  | driving read data on c_fall, counting bits on c_rise
// IGNORE | transaction done or not ours, wait for stop/start
module sccb_responder #(
    parameter logic [7:0] DEV_ID = 8'h42
) (
    input  logic       xclk,
    input  logic       rst_n,
    input  logic       sio_c,
    input  logic       sio_di,
    output logic       sio_do,
    output logic       sio_de,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ID,
        SUB,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    state_t      state;
    logic        c_s1, c_s2, c_h;
    logic        d_s1, d_s2, d_h;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_in;
    logic [7:0]  tx;
    logic        c_rise, c_fall, start, stop;

    // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            c_h  <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
            d_h  <= 1'b1;
        end else begin
            c_s1 <= sio_c;
            c_s2 <= c_s1;
            c_h  <= c_s2;
            d_s1 <= sio_di;
            d_s2 <= d_s1;
            d_h  <= d_s2;
        end
    end

    assign c_rise = c_s2 & ~c_h;
    assign c_fall = ~c_s2 & c_h;
    assign start  = c_s2 & c_h & d_h & ~d_s2;
    assign stop   = c_s2 & c_h & ~d_h & d_s2;

    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift_in  <= 8'h00;
            tx        <= 8'hFF;
            sio_do    <= 1'b1;
            sio_de    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            if (start) begin
                state   <= ID;
                bit_cnt <= 4'd0;
                sio_de  <= 1'b0;
                sio_do  <= 1'b1;
                busy    <= 1'b0;
            end else if (stop) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sio_de  <= 1'b0;
                sio_do  <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: busy <= 1'b0;
                    ID, SUB, WDATA: begin
                        if (c_rise) begin
                            if (bit_cnt != 4'd8) begin
                                shift_in <= {shift_in[6:0], d_s2};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end else begin
                                // Bit 8 (X) is not shifted; the byte is complete here.
                                bit_cnt <= 4'd0;
                                if (state == ID) begin
                                    if (shift_in[7:1] != DEV_ID[7:1]) begin
                                        state <= IGNORE;
                                    end else begin
                                        busy <= 1'b1;
                                        if (shift_in[0]) begin
                                            state <= RDATA;
                                            tx    <= reg_rdata;
                                        end else begin
                                            state <= SUB;
                                        end
                                    end
                                end else if (state == SUB) begin
                                    reg_addr <= shift_in;
                                    state    <= WDATA;
                                end else begin
                                    reg_wdata <= shift_in;
                                    reg_we    <= 1'b1;
                                    state     <= IGNORE;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (c_fall) begin
                            if (bit_cnt != 4'd8) begin
                                sio_de <= 1'b1;
                                sio_do <= tx[7];
                                tx     <= {tx[6:0], 1'b1};
                            end else begin
                                sio_de <= 1'b0;
                                sio_do <= 1'b1;
                            end
                        end else if (c_rise) begin
                            if (bit_cnt == 4'd8) begin
                                state   <= IGNORE;
                                bit_cnt <= 4'd0;
                                sio_de  <= 1'b0;
                                sio_do  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
